// File: rtl/spi_sensor_responder.sv
// SPI mode-0 slave fronting a small sensor model: CONVERT/CALIBRATE/WRITE/READ
// commands, each answered LATENCY frames later through a response queue.
module spi_sensor_responder #(
  parameter int unsigned WORD_W  = 16,
  parameter int unsigned LATENCY = 2,
  parameter logic [7:0]  CHIP_ID = 8'h5A
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs_b,
  input  logic              mosi,
  output logic              miso,
  output logic              frame_done,
  output logic [WORD_W-1:0] last_cmd,
  output logic [7:0]        abort_count
);

  localparam int unsigned CNT_W  = 5;
  localparam int unsigned CONV_W = 10;
  localparam int unsigned NREG   = 16;
  localparam int unsigned TAIL   = LATENCY - 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WORD_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT_HIGH
  } state_e;

  state_e              state_q;
  logic [1:0]          sclk_sync_q;
  logic [1:0]          cs_sync_q;
  logic [1:0]          mosi_sync_q;
  logic                sclk_prev_q;
  logic                cs_prev_q;
  logic [WORD_W-1:0]   rx_q;
  logic [WORD_W-1:0]   tx_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic                miso_q;
  logic                frame_done_q;
  logic [WORD_W-1:0]   last_cmd_q;
  logic [7:0]          abort_cnt_q;
  logic [CONV_W-1:0]   conv_cnt_q;
  logic [7:0]          regs_q  [NREG];
  logic [WORD_W-1:0]   queue_q [LATENCY];

  logic                sclk_s;
  logic                cs_s;
  logic                mosi_s;
  logic                sclk_rise;
  logic                sclk_fall;
  logic                cs_rise;
  logic                cs_fall;
  logic [WORD_W-1:0]   resp_d;
  logic                is_conv;
  logic                reg_wr;

  // Two-flop synchronizers plus one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk};
      cs_sync_q   <= {cs_sync_q[0], cs_b};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      sclk_prev_q <= sclk_sync_q[1];
      cs_prev_q   <= cs_sync_q[1];
    end
  end

  assign sclk_s    = sclk_sync_q[1];
  assign cs_s      = cs_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  // Command decode on the completed rx word; register reads see all earlier writes.
  always_comb begin
    resp_d  = '0;
    is_conv = (rx_q[15:14] == 2'b00);
    reg_wr  = (rx_q[15:14] == 2'b10) && (rx_q[13:12] == 2'b00);
    unique case (rx_q[15:14])
      2'b00: resp_d = {rx_q[13:8], conv_cnt_q};
      2'b01: resp_d = 16'h8000;
      2'b10: resp_d = {8'hFF, rx_q[7:0]};
      default: begin
        if (rx_q[13:12] == 2'b00) begin
          resp_d = {8'h00, regs_q[rx_q[11:8]]};
        end else if (rx_q[13:8] == 6'h3F) begin
          resp_d = {8'h00, CHIP_ID};
        end else begin
          resp_d = '0;
        end
      end
    endcase
  end

  // Frame FSM, shifters, response queue and sensor state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rx_q         <= '0;
      tx_q         <= '0;
      bit_cnt_q    <= '0;
      miso_q       <= 1'b0;
      frame_done_q <= 1'b0;
      last_cmd_q   <= '0;
      abort_cnt_q  <= '0;
      conv_cnt_q   <= '0;
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) queue_q[i] <= '0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // A low chip select without a seen falling edge is a frame we joined late.
          if (!cs_s) begin
            if (cs_fall) begin
              state_q   <= SHIFT;
              tx_q      <= queue_q[0];
              miso_q    <= queue_q[0][WORD_W-1];
              rx_q      <= '0;
              bit_cnt_q <= '0;
            end else begin
              state_q <= WAIT_HIGH;
            end
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state_q <= IDLE;
            miso_q  <= 1'b0;
            if (bit_cnt_q == CNT_FULL) begin
              frame_done_q <= 1'b1;
              last_cmd_q   <= rx_q;
              for (int unsigned i = 0; i + 1 < LATENCY; i++) queue_q[i] <= queue_q[i+1];
              queue_q[TAIL] <= resp_d;
              if (is_conv) conv_cnt_q <= conv_cnt_q + CONV_W'(1);
              if (reg_wr) regs_q[rx_q[11:8]] <= rx_q[7:0];
            end else if (abort_cnt_q != 8'hFF) begin
              abort_cnt_q <= abort_cnt_q + 8'd1;
            end
          end else if (sclk_rise) begin
            rx_q <= {rx_q[WORD_W-2:0], mosi_s};
            if (bit_cnt_q != CNT_MAX) bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          end else if (sclk_fall) begin
            tx_q   <= {tx_q[WORD_W-2:0], 1'b0};
            miso_q <= tx_q[WORD_W-2];
          end
        end
        WAIT_HIGH: begin
          if (cs_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // Blank miso in the same cycle the synchronized chip select goes high.
      if (cs_sync_q[0]) miso_q <= 1'b0;
    end
  end

  assign miso        = miso_q;
  assign frame_done  = frame_done_q;
  assign last_cmd    = last_cmd_q;
  assign abort_count = abort_cnt_q;

endmodule

// File: tb/tb_spi_sensor_responder.sv
// Directed bench for spi_sensor_responder: drives SPI mode-0 frames and checks
// the delayed responses, abort handling, reset behaviour and counter wrap.
`timescale 1ns/1ps
module tb_spi_sensor_responder;

  logic        clk;
  logic        reset;
  logic        sclk;
  logic        cs_b;
  logic        mosi;
  logic        miso;
  logic        frame_done;
  logic [15:0] last_cmd;
  logic [7:0]  abort_count;

  int          n_checks;
  int          n_bad;
  int          fd_cnt;
  int          fd0;
  logic [15:0] word;

  spi_sensor_responder #(
    .WORD_W  (16),
    .LATENCY (2),
    .CHIP_ID (8'h5A)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sclk        (sclk),
    .cs_b        (cs_b),
    .mosi        (mosi),
    .miso        (miso),
    .frame_done  (frame_done),
    .last_cmd    (last_cmd),
    .abort_count (abort_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // One SPI frame; miso is captured just before each rising sclk edge.
  task automatic spi_frame(input logic [15:0] cmd, input int nbits, input int half,
                           input int rst_at, output logic [15:0] rx);
    rx = '0;
    @(negedge clk);
    cs_b = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
      end
      mosi = (i < 16) ? cmd[15-i] : 1'b0;
      #(half);
      if (i < 16) rx = {rx[14:0], miso};
      sclk = 1'b1;
      #(half);
      sclk = 1'b0;
    end
    #(half);
    cs_b = 1'b1;
    mosi = 1'b0;
    #(half + 20);
  endtask

  task automatic xfer(input logic [15:0] cmd, input logic [15:0] exp, input string tag);
    logic [15:0] rx;
    spi_frame(cmd, 16, 50, -1, rx);
    check(tag, 32'(rx), 32'(exp));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_bad    = 0;
    fd_cnt   = 0;
    reset    = 1'b1;
    sclk     = 1'b0;
    cs_b     = 1'b1;
    mosi     = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_miso", 32'(miso), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    check("rst_last_cmd", 32'(last_cmd), 32'h0);
    check("rst_abort", 32'(abort_count), 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Three CONVERT ch5 frames: queue starts empty.
    fd0 = fd_cnt;
    xfer(16'h0500, 16'h0000, "conv_f1");
    xfer(16'h0500, 16'h0000, "conv_f2");
    xfer(16'h0500, 16'h1400, "conv_f3");
    check("conv_fd_pulses", 32'(fd_cnt - fd0), 32'd3);
    check("conv_last_cmd", 32'(last_cmd), 32'h0500);
    check("idle_miso", 32'(miso), 32'h0);

    // WRITE reg10 then READ it back.
    xfer(16'h8A3C, 16'h1401, "wr_f1");
    xfer(16'hCA00, 16'h1402, "rd_f2");
    xfer(16'h0000, 16'hFF3C, "wr_resp");
    xfer(16'h0000, 16'h003C, "rd_resp");

    // Chip id, out-of-range address, ignored write, calibrate.
    xfer(16'hFF00, 16'h0003, "id_f1");
    xfer(16'hD400, 16'h0004, "rd20_f1");
    xfer(16'h0000, 16'h005A, "chip_id");
    xfer(16'h9477, 16'h0000, "rd20_resp");
    xfer(16'hD400, 16'h0005, "rd20b_f1");
    xfer(16'h0000, 16'hFF77, "wr20_resp");
    xfer(16'h0000, 16'h0000, "rd20_after_wr");
    xfer(16'h4000, 16'h0006, "cal_f1");
    xfer(16'h0100, 16'h0007, "conv_ch1_f1");

    // Short and long frames interleaved with valid ones.
    fd0 = fd_cnt;
    spi_frame(16'h0200, 15, 50, -1, word);
    check("abort15_head", 32'(word), 32'h4000);
    check("abort15_count", 32'(abort_count), 32'd1);
    check("abort15_last_cmd", 32'(last_cmd), 32'h0100);
    xfer(16'h0200, 16'h8000, "cal_resp");
    spi_frame(16'h4000, 17, 50, -1, word);
    xfer(16'h4000, 16'h0408, "conv_ch1_resp");
    check("abort_count", 32'(abort_count), 32'd2);
    check("abort_last_cmd", 32'(last_cmd), 32'h4000);
    xfer(16'h0000, 16'h0809, "conv_ch2_resp");
    xfer(16'h0000, 16'h8000, "cal2_resp");
    check("abort_fd_pulses", 32'(fd_cnt - fd0), 32'd4);

    // Reset in the middle of a frame; the rest of that frame is ignored.
    fd0 = fd_cnt;
    spi_frame(16'h8155, 16, 50, 8, word);
    check("midrst_abort", 32'(abort_count), 32'h0);
    check("midrst_last_cmd", 32'(last_cmd), 32'h0);
    check("midrst_fd", 32'(fd_cnt - fd0), 32'd0);
    xfer(16'h8166, 16'h0000, "post_rst_f1");
    xfer(16'hC100, 16'h0000, "post_rst_f2");
    check("post_rst_last_cmd", 32'(last_cmd), 32'hC100);
    xfer(16'h4000, 16'hFF66, "post_rst_wr");
    xfer(16'h4000, 16'h0066, "post_rst_rd");
    check("post_rst_fd", 32'(fd_cnt - fd0), 32'd4);

    // Conversion counter wrap: 1023 fast frames, then observe 1021..1023 and 0.
    do_reset();
    for (int k = 0; k < 1023; k++) spi_frame(16'h0000, 16, 20, -1, word);
    check("wrap_abort", 32'(abort_count), 32'h0);
    xfer(16'h0300, 16'h03FD, "wrap_f1024");
    xfer(16'h0300, 16'h03FE, "wrap_f1025");
    xfer(16'h4000, 16'h0FFF, "wrap_cnt1023");
    xfer(16'h4000, 16'h0C00, "wrap_cnt0");

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_sensor_responder.md
SPI_SENSOR_RESPONDER -- requirements
Module: spi_sensor_responder

Interface
REQ-001 SHALL have parameter WORD_W, default 16, frame length in bits; only 16 is supported.
REQ-002 SHALL have parameter LATENCY, default 2, number of frames between a command and its response; legal range 1..3.
REQ-003 SHALL have parameter CHIP_ID, default 8'h5A, value returned when register 63 is read.
REQ-004 SHALL have port clk, input, 1, system clock; rising-edge active.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port sclk, input, 1, SPI clock from the master; asynchronous to clk.
REQ-007 SHALL have port cs_b, input, 1, active-low chip select from the master; asynchronous to clk.
REQ-008 SHALL have port mosi, input, 1, serial command data from the master.
REQ-009 SHALL have port miso, output, 1, serial response data to the master.
REQ-010 SHALL have port frame_done, output, 1, one-cycle pulse when a valid frame completes.
REQ-011 SHALL have port last_cmd, output, 16, the last valid command received.
REQ-012 SHALL have port abort_count, output, 8, number of aborted frames; saturates at 255.

Function
REQ-013 SHALL synchronize sclk, cs_b and mosi through 2-flop synchronizers.
REQ-014 SHALL detect sclk edges on the synchronized signal; correct operation requires clk >= 4x sclk.
REQ-015 SHALL use SPI mode 0: sample mosi on sclk rising edges, update miso on sclk falling edges, MSB first.
REQ-016 SHALL use states IDLE, SHIFT and WAIT_HIGH.
REQ-017 IDLE -> SHIFT on a synchronized cs_b falling edge; on entry, load the tx shifter with the response-queue head and drive its MSB on miso within 1 clk.
REQ-018 In SHIFT, each sclk rising edge SHALL shift mosi into the rx shifter and increment a 5-bit bit counter.
REQ-019 In SHIFT, each sclk falling edge SHALL shift the tx shifter left by 1, filling with 0.
REQ-020 SHIFT -> IDLE on a cs_b rising edge; the frame is valid only if the bit count equals 16.
REQ-021 On a valid frame, the block SHALL decode the command, push the response into the LATENCY-deep queue, update last_cmd, and pulse frame_done for 1 clk.
REQ-022 On an invalid frame (bit count != 16), the block SHALL discard the frame, leave the queue unchanged, and increment abort_count (saturating).
REQ-023 The bit counter SHALL saturate at 17, so any extra bits produce an abort.
REQ-024 A cs_b edge and an sclk edge in the same clk cycle SHALL be resolved with cs_b taking priority; that sclk edge is ignored.
REQ-025 miso SHALL be 0 whenever the synchronized cs_b is high.
REQ-026 CONVERT command (bits[15:14]=00, ch=bits[13:8]) SHALL respond with {ch[5:0], conv_cnt[9:0]}, then increment conv_cnt, which wraps 1023 -> 0.
REQ-027 CALIBRATE command (bits[15:14]=01) SHALL respond with 16'h8000 and have no other effect.
REQ-028 WRITE command (bits[15:14]=10, a=bits[13:8], d=bits[7:0]) SHALL write reg[a] when a<16, ignore the write when a>=16, and respond with {8'hFF, d} in both cases.
REQ-029 READ command (bits[15:14]=11, a=bits[13:8]) SHALL respond with {8'h00, reg[a]} for a<16, {8'h00, CHIP_ID} for a=63, and 16'h0000 otherwise.
REQ-030 A READ SHALL return register contents as of the end of its own frame, so a WRITE in an earlier frame is visible.
REQ-031 A response SHALL be shifted out during frame N+LATENCY, where N is its command frame; slots not yet filled SHALL return 16'h0000.

Reset
REQ-032 Reset SHALL force: state IDLE, miso=0, frame_done=0, last_cmd=0, abort_count=0, conv_cnt=0, all reg[0..15]=0, all queue entries=16'h0000.
REQ-033 Reset asserted mid-frame SHALL abandon the frame without counting an abort.
REQ-034 After reset, the block SHALL see cs_b high before accepting the next falling edge; a frame already in progress is ignored entirely.

Verification
REQ-035 Reset, then 3 frames of CONVERT ch5 (16'h0500) with LATENCY=2 -> miso words 0000, 0000, 1400; frame_done pulses 3 times.
REQ-036 WRITE 16'h8A3C (a=10, d=3C), READ 16'hCA00, then 2 dummy CONVERT ch0 frames -> miso in frames 3 and 4 are FF3C and 003C.
REQ-037 READ 16'hFF00 (a=63) followed by 2 frames -> 005A; READ a=20 -> 0000; WRITE a=20 then READ a=20 -> 0000.
REQ-038 Frames of 15 and 17 clocks interleaved with valid frames -> abort_count=2; queue order and last_cmd reflect only valid frames.
REQ-039 1024 CONVERT frames -> the response to the 1025th carries conv_cnt=0 (wrap).
REQ-040 Reset asserted at bit 8 of a frame, released, cs_b kept low until the end of that frame, then a normal frame -> the first frame is ignored, abort_count=0, and the normal frame is accepted.
